// File: rtl/regfile_wb_pkg.sv
// Shared constants for the ID/WB register-file slice: widths, the zero
// register index, the default pending-writer counter width and the ID
// forward-select encodings.
package regfile_wb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_NREG   = 32;
    localparam int DEF_PEND_W = 2;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // ID-stage operand source select
    typedef enum logic [1:0] {
        FA_ID_FILE   = 2'b00,
        FA_ID_EX_MEM = 2'b01,
        FA_ID_MEM_WB = 2'b10
    } fa_id_e;

    // A write-back or issue only counts when it targets a real register
    function automatic logic live_write(input logic en, input logic [REG_ADDR_W-1:0] addr);
        return en && (addr != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_wb_sb_counter.sv
// One pending-writer counter: saturating up/down, PEND_W bits wide.
// inc and dec together cancel. inc at full scale holds the count and
// pulses ovf for that cycle; dec at zero holds at zero silently.
module regfile_wb_sb_counter #(
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] cnt,
    output logic              ovf
);

    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};

    logic [PEND_W-1:0] cnt_r;
    logic [PEND_W-1:0] cnt_next_s;

    // Next-count and overflow pulse from the inc/dec request pair
    always_comb begin
        cnt_next_s = cnt_r;
        ovf        = 1'b0;
        if (inc && !dec) begin
            if (cnt_r == CNT_MAX) begin
                ovf = 1'b1;
            end else begin
                cnt_next_s = cnt_r + PEND_W'(1);
            end
        end else if (dec && !inc) begin
            if (cnt_r != '0) begin
                cnt_next_s = cnt_r - PEND_W'(1);
            end else begin
                cnt_next_s = cnt_r;
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Count register, cleared by the asynchronous reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_next_s;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/regfile_wb.sv
// Architectural register file with pending-write scoreboard.
// MEM_WB writes the file and retires a pending writer; ID issue adds one.
// Optional build macro REGFILE_BYPASS_EN: a same-cycle retire is visible on
// the read ports (data and busy) instead of only through MEM_WB forwarding.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = DEF_NREG,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MEM_WB_RegWrite,
    input  logic [REG_ADDR_W-1:0] MEM_WB_Write_register,
    input  logic [DATA_W-1:0]     MEM_WB_Write_data,
    input  logic [REG_ADDR_W-1:0] IF_ID_rs,
    input  logic [REG_ADDR_W-1:0] IF_ID_rt,
    output logic [DATA_W-1:0]     Read_data1,
    output logic [DATA_W-1:0]     Read_data2,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_cancel,
    output logic                  rs_busy,
    output logic                  rt_busy,
    output logic                  sb_overflow
);

    logic [DATA_W-1:0]            regs_r [NREG];
    logic [NREG-1:0][PEND_W-1:0]  cnt_s;
    logic [NREG-1:0]              ovf_s;
    logic                         sb_overflow_r;
    logic                         issue_ev_s;
    logic                         retire_ev_s;

    assign issue_ev_s  = live_write(issue_valid && !issue_cancel, issue_rd);
    assign retire_ev_s = live_write(MEM_WB_RegWrite, MEM_WB_Write_register);

    // Register 0 is hardwired zero and has no scoreboard entry
    assign cnt_s[0] = '0;
    assign ovf_s[0] = 1'b0;

    generate
        for (genvar g = 1; g < NREG; g++) begin : g_cnt
            logic inc_s;
            logic dec_s;
            assign inc_s = issue_ev_s  && (issue_rd == REG_ADDR_W'(g));
            assign dec_s = retire_ev_s && (MEM_WB_Write_register == REG_ADDR_W'(g));
            regfile_wb_sb_counter #(
                .PEND_W (PEND_W)
            ) u_cnt (
                .clk   (clk),
                .reset (reset),
                .inc   (inc_s),
                .dec   (dec_s),
                .cnt   (cnt_s[g]),
                .ovf   (ovf_s[g])
            );
        end
    endgenerate

    // Write-back into the file; $0 writes never land
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (retire_ev_s) begin
            regs_r[MEM_WB_Write_register] <= MEM_WB_Write_data;
        end else begin
            regs_r[MEM_WB_Write_register] <= regs_r[MEM_WB_Write_register];
        end
    end

    // Sticky record that some issue found its counter already full
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_overflow_r <= 1'b0;
        end else begin
            sb_overflow_r <= sb_overflow_r | (|ovf_s);
        end
    end

    assign sb_overflow = sb_overflow_r;

    // Port 1 read data and busy, zero register first
    always_comb begin
        Read_data1 = '0;
        rs_busy    = 1'b0;
        if (IF_ID_rs == REG_ZERO) begin
            Read_data1 = '0;
            rs_busy    = 1'b0;
`ifdef REGFILE_BYPASS_EN
        end else if (retire_ev_s && (MEM_WB_Write_register == IF_ID_rs)) begin
            Read_data1 = MEM_WB_Write_data;
            rs_busy    = (cnt_s[IF_ID_rs] > PEND_W'(1));
`endif
        end else begin
            Read_data1 = regs_r[IF_ID_rs];
            rs_busy    = (cnt_s[IF_ID_rs] != '0);
        end
    end

    // Port 2 read data and busy, zero register first
    always_comb begin
        Read_data2 = '0;
        rt_busy    = 1'b0;
        if (IF_ID_rt == REG_ZERO) begin
            Read_data2 = '0;
            rt_busy    = 1'b0;
`ifdef REGFILE_BYPASS_EN
        end else if (retire_ev_s && (MEM_WB_Write_register == IF_ID_rt)) begin
            Read_data2 = MEM_WB_Write_data;
            rt_busy    = (cnt_s[IF_ID_rt] > PEND_W'(1));
`endif
        end else begin
            Read_data2 = regs_r[IF_ID_rt];
            rt_busy    = (cnt_s[IF_ID_rt] != '0);
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed vector table, asynchronous
// reset mid-run, then a random issue/retire stream against a reference model.
module tb_regfile_wb;

    localparam int NR   = 32;
    localparam int PMAX = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_Write_register;
    logic [31:0] MEM_WB_Write_data;
    logic [4:0]  IF_ID_rs;
    logic [4:0]  IF_ID_rt;
    logic [31:0] Read_data1;
    logic [31:0] Read_data2;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_cancel;
    logic        rs_busy;
    logic        rt_busy;
    logic        sb_overflow;

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk                   (clk),
        .reset                 (reset),
        .MEM_WB_RegWrite       (MEM_WB_RegWrite),
        .MEM_WB_Write_register (MEM_WB_Write_register),
        .MEM_WB_Write_data     (MEM_WB_Write_data),
        .IF_ID_rs              (IF_ID_rs),
        .IF_ID_rt              (IF_ID_rt),
        .Read_data1            (Read_data1),
        .Read_data2            (Read_data2),
        .issue_valid           (issue_valid),
        .issue_rd              (issue_rd),
        .issue_cancel          (issue_cancel),
        .rs_busy               (rs_busy),
        .rt_busy               (rt_busy),
        .sb_overflow           (sb_overflow)
    );

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        rsb;
        logic        rtb;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        iv;
        logic [4:0]  ird;
        logic        ic;
        exp_t        e;
    } vec_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_mem [NR];
    int          m_cnt [NR];
    logic        m_ovf;

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] rs, input logic [4:0] rt, input logic iv,
                                input logic [4:0] ird, input logic ic, input logic [31:0] rd1,
                                input logic [31:0] rd2, input logic rsb, input logic rtb,
                                input logic ovf);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.rs = rs; v.rt = rt;
        v.iv = iv; v.ird = ird; v.ic = ic;
        v.e.rd1 = rd1; v.e.rd2 = rd2; v.e.rsb = rsb; v.e.rtb = rtb; v.e.ovf = ovf;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mem[i] = 32'd0;
            m_cnt[i] = 0;
        end
        m_ovf = 1'b0;
    endtask

    function automatic exp_t model_exp(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        exp_t e;
        e.rd1 = (rs == 5'd0) ? 32'd0 : m_mem[rs];
        e.rd2 = (rt == 5'd0) ? 32'd0 : m_mem[rt];
        e.rsb = (rs != 5'd0) && (m_cnt[rs] != 0);
        e.rtb = (rt != 5'd0) && (m_cnt[rt] != 0);
`ifdef REGFILE_BYPASS_EN
        if (we && wa != 5'd0 && wa == rs) begin
            e.rd1 = wd;
            e.rsb = (m_cnt[rs] > 1);
        end
        if (we && wa != 5'd0 && wa == rt) begin
            e.rd2 = wd;
            e.rtb = (m_cnt[rt] > 1);
        end
`endif
        e.ovf = m_ovf;
        return e;
    endfunction

    task automatic model_step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic iv, input logic [4:0] ird, input logic ic);
        logic iev;
        logic rev;
        iev = iv && !ic && (ird != 5'd0);
        rev = we && (wa != 5'd0);
        if (rev) m_mem[wa] = wd;
        if (!(iev && rev && ird == wa)) begin
            if (iev) begin
                if (m_cnt[ird] == PMAX) m_ovf = 1'b1;
                else m_cnt[ird] = m_cnt[ird] + 1;
            end
            if (rev && m_cnt[wa] != 0) m_cnt[wa] = m_cnt[wa] - 1;
        end
    endtask

    // Drive one cycle at the falling edge, check before the rising edge
    task automatic apply(input string tag, input int idx, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] rs, input logic [4:0] rt,
                         input logic iv, input logic [4:0] ird, input logic ic, input exp_t e);
        exp_t got;
        MEM_WB_RegWrite = we; MEM_WB_Write_register = wa; MEM_WB_Write_data = wd;
        IF_ID_rs = rs; IF_ID_rt = rt;
        issue_valid = iv; issue_rd = ird; issue_cancel = ic;
        sbq.push_back(e);
        #2;
        got = sbq.pop_front();
        checks++;
        if (Read_data1 !== got.rd1 || Read_data2 !== got.rd2 || rs_busy !== got.rsb ||
            rt_busy !== got.rtb || sb_overflow !== got.ovf) begin
            failures++;
            $display("FAIL %s[%0d] actual rd1=%h rd2=%h rs_busy=%b rt_busy=%b ovf=%b required rd1=%h rd2=%h rs_busy=%b rt_busy=%b ovf=%b",
                     tag, idx, Read_data1, Read_data2, rs_busy, rt_busy, sb_overflow,
                     got.rd1, got.rd2, got.rsb, got.rtb, got.ovf);
        end
        @(posedge clk);
        model_step(we, wa, wd, iv, ird, ic);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (Read_data1 !== 32'd0 || Read_data2 !== 32'd0 || rs_busy !== 1'b0 ||
            rt_busy !== 1'b0 || sb_overflow !== 1'b0) begin
            failures++;
            $display("FAIL %s actual rd1=%h rd2=%h rs_busy=%b rt_busy=%b ovf=%b required all zero",
                     tag, Read_data1, Read_data2, rs_busy, rt_busy, sb_overflow);
        end
    endtask

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [31];
        exp_t e;
        logic        we, iv, ic;
        logic [4:0]  wa, rs, rt, ird;
        logic [31:0] wd;

        reset = 1'b0;
        MEM_WB_RegWrite = 1'b0; MEM_WB_Write_register = 5'd0; MEM_WB_Write_data = 32'd0;
        IF_ID_rs = 5'd5; IF_ID_rt = 5'd9;
        issue_valid = 1'b0; issue_rd = 5'd0; issue_cancel = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        #1 reset = 1'b1;
        @(negedge clk);

        // we wa wd rs rt iv ird ic | rd1 rd2 rs_busy rt_busy ovf
        vecs[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 5'd0, 32'h1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0, 5'd0, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        vecs[5]  = mk(1'b1, 5'd7, 32'h77, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 32'h77, 32'd0, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(1'b1, 5'd7, 32'h78, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 32'h78, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 32'h78, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 5'd7, 32'h79, 5'd5, 5'd0, 1'b1, 5'd7, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 32'h79, 32'd0, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(1'b1, 5'd7, 32'h7A, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 5'd0, 32'h0, 5'd7, 5'd9, 1'b0, 5'd0, 1'b0, 32'h7A, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b1, 5'd9, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[16] = mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b1, 5'd9, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b1, 5'd9, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        vecs[18] = mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b1, 5'd9, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        vecs[19] = mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b1, 5'd9, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        vecs[20] = mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        vecs[21] = mk(1'b1, 5'd9, 32'h99, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b1);
        vecs[22] = mk(1'b1, 5'd9, 32'h9A, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b1);
        vecs[23] = mk(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 32'h9A, 32'd0, 1'b1, 1'b0, 1'b1);
        vecs[24] = mk(1'b1, 5'd9, 32'h9B, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, 1'b0, 1'b1);
        vecs[25] = mk(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 32'h9B, 32'd0, 1'b0, 1'b0, 1'b1);
        vecs[26] = mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
`ifdef REGFILE_BYPASS_EN
        vecs[27] = mk(1'b1, 5'd3, 32'h55, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 32'd0, 32'h55, 1'b0, 1'b0, 1'b1);
`else
        vecs[27] = mk(1'b1, 5'd3, 32'h55, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
`endif
        vecs[28] = mk(1'b0, 5'd0, 32'h0, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 32'd0, 32'h55, 1'b0, 1'b0, 1'b1);
        vecs[29] = mk(1'b1, 5'd5, 32'h1234, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        vecs[30] = mk(1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 32'h1234, 32'h1234, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 31; i++) begin
            apply("vec", i, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rs, vecs[i].rt,
                  vecs[i].iv, vecs[i].ird, vecs[i].ic, vecs[i].e);
        end

        // Mid-run asynchronous reset with live state and a pending writer on r9
        apply("pre_reset_issue", 0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd9, 1'b1, 5'd9, 1'b0,
              model_exp(1'b0, 5'd0, 32'd0, 5'd5, 5'd9));
        MEM_WB_RegWrite = 1'b0; issue_valid = 1'b0;
        IF_ID_rs = 5'd5; IF_ID_rt = 5'd9;
        #1 reset = 1'b0;
        #1 check_zero("midrun_reset_low");
        @(negedge clk);
        check_zero("midrun_reset_held");
        #1 reset = 1'b1;
        model_reset();
        @(negedge clk);
        apply("post_reset", 0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd9, 1'b0, 5'd0, 1'b0,
              model_exp(1'b0, 5'd0, 32'd0, 5'd5, 5'd9));

        // Random issue/retire stream on a small register window
        for (int n = 0; n < 400; n++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 7));
            wd  = $urandom;
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            iv  = 1'($urandom_range(0, 1));
            ird = 5'($urandom_range(0, 7));
            ic  = ($urandom_range(0, 3) == 0);
            e   = model_exp(we, wa, wd, rs, rt);
            apply("rand", n, we, wa, wd, rs, rt, iv, ird, ic, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
